i2s_sample_sched: RTL and testbench

I2S_SAMPLE_SCHED -- requirements
Module: i2s_sample_sched

---
 rtl/i2s_sample_sched.sv | 185 ++++++++++++++++++
 tb/tb_i2s_sample_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_sched.sv
// i2s_sample_sched: stereo sample scheduler between an AMCLK-domain input strobe
// and a fixed-rate output tick.
//
// Incoming stereo pairs are buffered in a small FIFO. A free-running divider
// produces one output tick every MCLK_DIVIDER cycles. The FSM waits for PREFILL
// entries and then pops one pair per tick. Underruns and overflows are reported
// through sticky flags.
//
// Optional build macro:
//   I2S_SCHED_MUTE_ON_UNDERRUN_EN
//     Defined:   underrun and RECOVER ticks output 0/0.
//     Undefined: those ticks repeat the last popped pair.
//
// Ports:
//   AMCLK_i, reset_n             clock (rising edge) and async active-low reset
//   enable_i                     scheduler enable; low flushes the FIFO and idles
//   in_valid_i                   one-cycle strobe marking a new input pair
//   in_left_i, in_right_i        signed input pair
//   clr_status_i                 clears underrun_o / overflow_o
//   out_left_o, out_right_o      signed scheduled output pair
//   out_valid_o                  one-cycle pulse per output tick
//   fill_o                       FIFO occupancy, 0..FIFO_DEPTH
//   underrun_o, overflow_o       sticky error flags
//   state_o                      IDLE=0, PREFILL=1, RUN=2, RECOVER=3
module i2s_sample_sched #(
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned MCLK_DIVIDER = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PREFILL      = 2
) (
  input  logic                          AMCLK_i,
  input  logic                          reset_n,
  input  logic                          enable_i,
  input  logic                          in_valid_i,
  input  logic signed [DATA_BITS-1:0]   in_left_i,
  input  logic signed [DATA_BITS-1:0]   in_right_i,
  input  logic                          clr_status_i,
  output logic signed [DATA_BITS-1:0]   out_left_o,
  output logic signed [DATA_BITS-1:0]   out_right_o,
  output logic                          out_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic                          underrun_o,
  output logic                          overflow_o,
  output logic [1:0]                    state_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned DW = (MCLK_DIVIDER > 1) ? $clog2(MCLK_DIVIDER) : 1;
  localparam int unsigned PW = 2 * DATA_BITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PREFILL = 2'd1,
    S_RUN     = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [PW-1:0]   mem [FIFO_DEPTH];

  logic            tick_c;
  logic            full_c;
  logic            empty_c;
  logic            ready_c;
  logic            pop_c;
  logic            push_c;
  logic            drop_c;
  logic            under_c;
  logic            mute_c;
  logic [PW-1:0]   head_c;

  assign state_o = state;

  // Datapath decisions for the current cycle.
  always_comb begin
    tick_c  = (div_cnt == DW'(MCLK_DIVIDER - 1));
    full_c  = (fill_o == FW'(FIFO_DEPTH));
    empty_c = (fill_o == '0);
    ready_c = (fill_o >= FW'(PREFILL));
    head_c  = mem[rd_ptr];
    // The PREFILL->RUN tick pops as well, so the first pulse carries the first pair.
    pop_c   = enable_i && tick_c &&
              (((state == S_RUN) && !empty_c) || ((state == S_PREFILL) && ready_c));
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    push_c  = enable_i && in_valid_i && (!full_c || pop_c);
    drop_c  = enable_i && in_valid_i && full_c && !pop_c;
    under_c = enable_i && tick_c && (state == S_RUN) && empty_c;
    mute_c  = enable_i && tick_c && (under_c || (state == S_RECOVER));
  end

  // Free-running output tick divider.
  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // FIFO storage; contents are don't-care after reset or flush.
  always_ff @(posedge AMCLK_i) begin
    if (push_c) begin
      mem[wr_ptr] <= {in_left_i, in_right_i};
    end
  end

  // FSM, FIFO pointers and registered output pair.
  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_o      <= '0;
      out_left_o  <= '0;
      out_right_o <= '0;
      out_valid_o <= 1'b0;
    end else begin
      out_valid_o <= tick_c;
      if (!enable_i) begin
        state       <= S_IDLE;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        fill_o      <= '0;
        out_left_o  <= '0;
        out_right_o <= '0;
      end else begin
        if (push_c) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop_c) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        fill_o <= fill_o + FW'(push_c) - FW'(pop_c);

        if (pop_c) begin
          out_left_o  <= head_c[PW-1:DATA_BITS];
          out_right_o <= head_c[DATA_BITS-1:0];
        end else if (mute_c) begin
`ifdef I2S_SCHED_MUTE_ON_UNDERRUN_EN
          out_left_o  <= '0;
          out_right_o <= '0;
`else
          // Holding the registers repeats the last popped pair.
          out_left_o  <= out_left_o;
          out_right_o <= out_right_o;
`endif
        end

        case (state)
          S_IDLE:    state <= S_PREFILL;
          S_PREFILL: if (tick_c && ready_c) state <= S_RUN;
          S_RUN:     if (tick_c && empty_c) state <= S_RECOVER;
          S_RECOVER: if (tick_c && ready_c) state <= S_RUN;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

  // Sticky status flags; a set event outranks a clear in the same cycle.
  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      underrun_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (under_c) begin
        underrun_o <= 1'b1;
      end else if (clr_status_i) begin
        underrun_o <= 1'b0;
      end
      if (drop_c) begin
        overflow_o <= 1'b1;
      end else if (clr_status_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_sample_sched.sv
// Testbench for i2s_sample_sched with default parameters
// (DATA_BITS=16, MCLK_DIVIDER=16, FIFO_DEPTH=4, PREFILL=2).
// Expected output pairs are queued when pushed and popped on each output pulse.
module tb_i2s_sample_sched;

  logic               AMCLK_i = 1'b0;
  logic               reset_n;
  logic               enable_i;
  logic               in_valid_i;
  logic signed [15:0] in_left_i;
  logic signed [15:0] in_right_i;
  logic               clr_status_i;
  logic signed [15:0] out_left_o;
  logic signed [15:0] out_right_o;
  logic               out_valid_o;
  logic [2:0]         fill_o;
  logic               underrun_o;
  logic               overflow_o;
  logic [1:0]         state_o;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] q_left[$];
  logic [15:0] q_right[$];

  i2s_sample_sched #(
    .DATA_BITS(16), .MCLK_DIVIDER(16), .FIFO_DEPTH(4), .PREFILL(2)
  ) dut (
    .AMCLK_i(AMCLK_i), .reset_n(reset_n), .enable_i(enable_i),
    .in_valid_i(in_valid_i), .in_left_i(in_left_i), .in_right_i(in_right_i),
    .clr_status_i(clr_status_i), .out_left_o(out_left_o), .out_right_o(out_right_o),
    .out_valid_o(out_valid_o), .fill_o(fill_o), .underrun_o(underrun_o),
    .overflow_o(overflow_o), .state_o(state_o)
  );

  always #5 AMCLK_i = ~AMCLK_i;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge AMCLK_i);
      #1;
    end
  endtask

  // Advance until an output pulse is seen; bounded so a dead divider cannot hang.
  task automatic wait_pulse(output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (out_valid_o !== 1'b1 && cycles < 64);
    if (out_valid_o !== 1'b1) begin
      n_checks++; n_fails++;
      $display("FAIL pulse_timeout: out_valid_o=%b after %0d cycles, expected 1", out_valid_o, cycles);
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r, input bit keep);
    in_valid_i = 1'b1;
    in_left_i  = l;
    in_right_i = r;
    if (keep) begin
      q_left.push_back(l);
      q_right.push_back(r);
    end
    step(1);
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    reset_n = 1'b0; enable_i = 1'b0; in_valid_i = 1'b0;
    in_left_i = '0; in_right_i = '0; clr_status_i = 1'b0;
    step(3);
    n_checks++;
    if ({state_o, fill_o, out_valid_o, underrun_o, overflow_o} !== 8'h00 ||
        out_left_o !== 16'h0 || out_right_o !== 16'h0) begin
      n_fails++;
      $display("FAIL reset_state: state=%0d fill=%0d v=%b u=%b o=%b l=%h r=%h, expected all 0",
               state_o, fill_o, out_valid_o, underrun_o, overflow_o, out_left_o, out_right_o);
    end
    reset_n = 1'b1;
    wait_pulse(c);
    wait_pulse(c);
    n_checks++;
    if (c !== 16) begin
      n_fails++; $display("FAIL tick_period: got %0d cycles, expected 16", c);
    end
    n_checks++;
    if (state_o !== 2'd0 || out_left_o !== 16'h0) begin
      n_fails++; $display("FAIL idle_tick: state=%0d l=%h, expected 0/0000", state_o, out_left_o);
    end
    step(1);
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fails++; $display("FAIL pulse_width: out_valid_o=%b, expected 0", out_valid_o);
    end
  endtask

  task automatic test_prefill_run();
    int c;
    logic [15:0] el, er;
    wait_pulse(c);
    enable_i = 1'b1;
    push_pair(16'h1111, 16'h2222, 1'b1);
    push_pair(16'h3333, 16'h4444, 1'b1);
    n_checks++;
    if (state_o !== 2'd1 || fill_o !== 3'd2) begin
      n_fails++; $display("FAIL prefill_state: state=%0d fill=%0d, expected 1/2", state_o, fill_o);
    end
    wait_pulse(c);
    n_checks++;
    if (state_o !== 2'd2) begin
      n_fails++; $display("FAIL run_entry: state=%0d, expected 2", state_o);
    end
    el = q_left.pop_front(); er = q_right.pop_front();
    n_checks++;
    if (out_left_o !== el || out_right_o !== er) begin
      n_fails++; $display("FAIL first_pair: got %h/%h, expected %h/%h", out_left_o, out_right_o, el, er);
    end
  endtask

  task automatic test_underrun_recover();
    int c;
    logic [15:0] el, er;
    wait_pulse(c);
    el = q_left.pop_front(); er = q_right.pop_front();
    n_checks++;
    if (out_left_o !== el || out_right_o !== er || fill_o !== 3'd0) begin
      n_fails++; $display("FAIL second_pair: got %h/%h fill=%0d, expected %h/%h fill=0",
                          out_left_o, out_right_o, fill_o, el, er);
    end
    wait_pulse(c);
`ifdef I2S_SCHED_MUTE_ON_UNDERRUN_EN
    el = 16'h0; er = 16'h0;
`endif
    n_checks++;
    if (state_o !== 2'd3 || underrun_o !== 1'b1) begin
      n_fails++; $display("FAIL underrun_flag: state=%0d u=%b, expected 3/1", state_o, underrun_o);
    end
    n_checks++;
    if (out_left_o !== el || out_right_o !== er) begin
      n_fails++; $display("FAIL underrun_data: got %h/%h, expected %h/%h", out_left_o, out_right_o, el, er);
    end
    push_pair(16'h5555, 16'h6666, 1'b1);
    push_pair(16'h7777, 16'h8888, 1'b1);
    wait_pulse(c);
    n_checks++;
    if (state_o !== 2'd2 || fill_o !== 3'd2 || out_left_o !== el || out_right_o !== er) begin
      n_fails++; $display("FAIL recover_exit: state=%0d fill=%0d out=%h/%h, expected 2/2 %h/%h",
                          state_o, fill_o, out_left_o, out_right_o, el, er);
    end
    wait_pulse(c);
    el = q_left.pop_front(); er = q_right.pop_front();
    n_checks++;
    if (out_left_o !== el || out_right_o !== er) begin
      n_fails++; $display("FAIL recover_pop: got %h/%h, expected %h/%h", out_left_o, out_right_o, el, er);
    end
  endtask

  task automatic test_stream();
    int c;
    logic [15:0] el, er;
    wait_pulse(c);
    enable_i = 1'b0; clr_status_i = 1'b1;
    step(1);
    enable_i = 1'b1; clr_status_i = 1'b0;
    q_left.delete(); q_right.delete();
    n_checks++;
    if (underrun_o !== 1'b0 || fill_o !== 3'd0) begin
      n_fails++; $display("FAIL flush_clear: u=%b fill=%0d, expected 0/0", underrun_o, fill_o);
    end
    push_pair(16'($urandom), 16'($urandom), 1'b1);
    push_pair(16'($urandom), 16'($urandom), 1'b1);
    for (int i = 0; i < 8; i++) begin
      wait_pulse(c);
      el = q_left.pop_front(); er = q_right.pop_front();
      n_checks++;
      if (state_o !== 2'd2 || out_left_o !== el || out_right_o !== er) begin
        n_fails++; $display("FAIL stream_%0d: state=%0d out=%h/%h, expected 2 %h/%h",
                            i, state_o, out_left_o, out_right_o, el, er);
      end
      push_pair(16'($urandom), 16'($urandom), 1'b1);
    end
    n_checks++;
    if (underrun_o !== 1'b0) begin
      n_fails++; $display("FAIL stream_underrun: u=%b, expected 0", underrun_o);
    end
  endtask

  task automatic test_overflow();
    int c;
    logic [15:0] el, er;
    wait_pulse(c);
    enable_i = 1'b0;
    step(1);
    enable_i = 1'b1;
    q_left.delete(); q_right.delete();
    for (int i = 1; i <= 5; i++) begin
      push_pair(16'(16'h1000 * i), 16'(16'h0100 * i), i <= 4);
    end
    n_checks++;
    if (fill_o !== 3'd4 || overflow_o !== 1'b1 || state_o !== 2'd1) begin
      n_fails++; $display("FAIL overflow_fill: fill=%0d o=%b state=%0d, expected 4/1/1",
                          fill_o, overflow_o, state_o);
    end
    // Pulse seen at edge P; flush + 5 pushes reach P+6, so 9 more reach P+15.
    step(9);
    push_pair(16'h6006, 16'h0660, 1'b1);
    el = q_left.pop_front(); er = q_right.pop_front();
    n_checks++;
    if (out_valid_o !== 1'b1 || fill_o !== 3'd4 || state_o !== 2'd2) begin
      n_fails++; $display("FAIL push_pop_full: v=%b fill=%0d state=%0d, expected 1/4/2",
                          out_valid_o, fill_o, state_o);
    end
    n_checks++;
    if (out_left_o !== el || out_right_o !== er) begin
      n_fails++; $display("FAIL overflow_head: got %h/%h, expected %h/%h", out_left_o, out_right_o, el, er);
    end
  endtask

  task automatic test_clr_status();
    in_valid_i = 1'b1; in_left_i = 16'h7007; in_right_i = 16'h0770; clr_status_i = 1'b1;
    step(1);
    in_valid_i = 1'b0; clr_status_i = 1'b0;
    n_checks++;
    if (overflow_o !== 1'b1 || fill_o !== 3'd4) begin
      n_fails++; $display("FAIL clr_vs_set: o=%b fill=%0d, expected 1/4", overflow_o, fill_o);
    end
    clr_status_i = 1'b1;
    step(1);
    clr_status_i = 1'b0;
    n_checks++;
    if (overflow_o !== 1'b0) begin
      n_fails++; $display("FAIL clr_alone: o=%b, expected 0", overflow_o);
    end
  endtask

  task automatic test_disable();
    int c;
    logic [15:0] el, er;
    wait_pulse(c);
    el = q_left.pop_front(); er = q_right.pop_front();
    n_checks++;
    if (out_left_o !== el || out_right_o !== er || fill_o !== 3'd3 || state_o !== 2'd2) begin
      n_fails++; $display("FAIL pre_disable: out=%h/%h fill=%0d state=%0d, expected %h/%h 3 2",
                          out_left_o, out_right_o, fill_o, state_o, el, er);
    end
    enable_i = 1'b0;
    step(1);
    q_left.delete(); q_right.delete();
    n_checks++;
    if (state_o !== 2'd0 || fill_o !== 3'd0 || out_left_o !== 16'h0 ||
        out_right_o !== 16'h0 || out_valid_o !== 1'b0) begin
      n_fails++; $display("FAIL disable_flush: state=%0d fill=%0d out=%h/%h v=%b, expected all 0",
                          state_o, fill_o, out_left_o, out_right_o, out_valid_o);
    end
    enable_i = 1'b1;
    step(1);
    n_checks++;
    if (state_o !== 2'd1) begin
      n_fails++; $display("FAIL reenable: state=%0d, expected 1", state_o);
    end
  endtask

  task automatic test_async_reset();
    push_pair(16'hAAAA, 16'hBBBB, 1'b0);
    push_pair(16'hCCCC, 16'hDDDD, 1'b0);
    n_checks++;
    if (fill_o !== 3'd2) begin
      n_fails++; $display("FAIL pre_reset_fill: fill=%0d, expected 2", fill_o);
    end
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({state_o, fill_o, out_valid_o, underrun_o, overflow_o} !== 8'h00 ||
        out_left_o !== 16'h0 || out_right_o !== 16'h0) begin
      n_fails++; $display("FAIL async_reset: state=%0d fill=%0d v=%b u=%b o=%b l=%h r=%h, expected all 0",
                          state_o, fill_o, out_valid_o, underrun_o, overflow_o, out_left_o, out_right_o);
    end
    enable_i = 1'b0;
    #2;
    reset_n = 1'b1;
    step(1);
    n_checks++;
    if (state_o !== 2'd0 || fill_o !== 3'd0) begin
      n_fails++; $display("FAIL post_reset: state=%0d fill=%0d, expected 0/0", state_o, fill_o);
    end
  endtask

  initial begin
    test_reset();
    test_prefill_run();
    test_underrun_recover();
    test_stream();
    test_overflow();
    test_clr_status();
    test_disable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
